sw_time_cnt: RTL and testbench
==============================

SW_TIME_CNT -- requirements
Module: sw_time_cnt

Interface
REQ-001 The block SHALL have parameter MAX_MIN, default 7'd59, giving the highest minute value (legal range 1..99).
REQ-002 The block SHALL have parameter OVF_STOP, default 1'b0: 0 wraps to zero at overflow, 1 stops at overflow.
REQ-003 The block SHALL have port clk  input  1  system clock, 50 MHz.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port tick_10ms  input  1  one-clk pulse every 10 ms from the 10 ms tick counter.
REQ-006 The block SHALL have port start_stop  input  1  one-clk pulse that toggles between running and paused.
REQ-007 The block SHALL have port clear  input  1  one-clk pulse that zeroes the count and returns to IDLE.
REQ-008 The block SHALL have port cs_bcd  output  8  centiseconds as two BCD digits, 00..99.
REQ-009 The block SHALL have port sec_bcd  output  8  seconds as two BCD digits, 00..59.
REQ-010 The block SHALL have port min_bcd  output  8  minutes as two BCD digits, 00..MAX_MIN.
REQ-011 The block SHALL have port running  output  1  high while state is RUN.
REQ-012 The block SHALL have port ovf  output  1  one-clk pulse when the count passes MAX_MIN:59.99.

Function
REQ-013 The state machine SHALL have states IDLE, RUN and PAUSE.
REQ-014 On start_stop, IDLE and PAUSE SHALL go to RUN, and RUN SHALL go to PAUSE.
REQ-015 On clear, every state SHALL go to IDLE and all digits SHALL become 0 on the next clock.
REQ-016 clear SHALL take priority over start_stop and tick_10ms in the same cycle.
REQ-017 The count SHALL increment by 0.01 s on the clock edge after tick_10ms is sampled high, but only if the state is RUN in that cycle.
REQ-018 If tick_10ms and start_stop arrive in the same cycle in RUN, the count SHALL increment and the state SHALL go to PAUSE.
REQ-019 If tick_10ms and start_stop arrive in the same cycle in IDLE or PAUSE, the count SHALL NOT increment.
REQ-020 Each BCD digit SHALL carry into the next digit: cs 99->00 carries into sec, and sec 59->00 carries into min.
REQ-021 The ones digit SHALL wrap 9->0 and SHALL never hold a value from A to F.
REQ-022 At MAX_MIN:59.99 with OVF_STOP=0, the next counted tick SHALL wrap to 00:00.00, pulse ovf and stay in RUN.
REQ-023 At MAX_MIN:59.99 with OVF_STOP=1, the next counted tick SHALL hold the value, pulse ovf and go to PAUSE.
REQ-024 All outputs SHALL be registered; running SHALL follow the state with no combinational path from the inputs.

Reset
REQ-025 When rst=0, the state SHALL become IDLE, all BCD outputs 8'h00, running 0, ovf 0 and any lap hold 0, asynchronously.
REQ-026 If reset is asserted mid-count, the count SHALL be lost, and after release counting SHALL need a new start_stop.

Configuration
REQ-027 Macro SW_LAP_EN SHALL, when defined, add input port lap (1-bit pulse) and output port lap_hold (1 bit).
REQ-028 With SW_LAP_EN, a lap pulse in RUN with lap_hold=0 SHALL capture the live count into the display registers and set lap_hold=1.
REQ-029 With SW_LAP_EN, while lap_hold=1 the outputs SHALL show the captured value while the live count keeps advancing.
REQ-030 With SW_LAP_EN, a lap pulse with lap_hold=1 SHALL clear lap_hold, and the outputs SHALL show the live count again on the next clock.
REQ-031 With SW_LAP_EN, clear SHALL also reset lap_hold to 0, and a lap pulse in IDLE or PAUSE SHALL be ignored.
REQ-032 Without SW_LAP_EN, the ports lap and lap_hold SHALL NOT exist and the outputs SHALL always show the live count.

Structure
REQ-033 Package sw_pkg SHALL hold the state enum sw_state_t (IDLE, RUN, PAUSE), the constant CS_MAX=99, the constant SEC_MAX=59 and a 2-digit BCD typedef bcd2_t.
REQ-034 Sub-module bcd2_cnt (2-digit BCD counter with enable, clear, parameterised limit and carry out) SHALL be instantiated three times: cs, sec and min.

Verification
REQ-035 The bench SHALL check: reset, then start_stop, then 100 ticks -> cs_bcd=00, sec_bcd=01, min_bcd=00, running=1.
REQ-036 The bench SHALL check: preload 00:59.99, then 1 tick -> 01:00.00, with no A-F digit on any cycle.
REQ-037 The bench SHALL check: at 59:59.99 with OVF_STOP=0, 1 tick -> 00:00.00, ovf high one cycle, running=1; with OVF_STOP=1 the value is held and running=0.
REQ-038 The bench SHALL check: tick and start_stop in the same cycle in RUN at 00:00.05 -> 00:00.06 and state PAUSE; a further tick -> still 00:00.06.
REQ-039 The bench SHALL check: clear with start_stop and tick in the same cycle at 00:12.34 -> 00:00.00 and running=0.
REQ-040 With SW_LAP_EN, the bench SHALL check: lap at 00:03.00, then 200 ticks -> outputs hold 00:03.00; a second lap -> outputs show 00:05.00.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch time counter.
// Holds the FSM state enum, digit limits and the 2-digit BCD type.
package sw_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens = 4'(v / 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd2_cnt.sv
// Two-digit BCD counter with enable, clear, wrap at LIMIT and carry out.
// Exposes its next value so the top can keep zero-lag display registers.
module bcd2_cnt
    import sw_pkg::*;
#(
    parameter int unsigned LIMIT = 99
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  en,
    output bcd2_t q_next,
    output logic  at_lim,
    output logic  carry
);

    localparam bcd2_t LIM = to_bcd2(LIMIT);

    bcd2_t q;

    // NOTE: every signal gets a default first in always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        q_next = q;
        at_lim = (q == LIM);
        carry  = en && at_lim;
        if (clr) begin
            q_next = '0;
        end else if (en) begin
            if (at_lim) begin
                q_next = '0;
            end else if (q.ones == 4'd9) begin
                q_next.ones = 4'd0;
                q_next.tens = q.tens + 4'd1;
            end else begin
                q_next.ones = q.ones + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= q_next;
    end

endmodule

// File: rtl/sw_time_cnt.sv
// Stopwatch time counter: MM:SS.cc in BCD, IDLE/RUN/PAUSE control, overflow wrap or stop.
// Optional lap-hold display enabled by defining SW_LAP_EN.
module sw_time_cnt
    import sw_pkg::*;
#(
    parameter logic [6:0] MAX_MIN  = 7'd59,
    parameter logic       OVF_STOP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_10ms,
    input  logic       start_stop,
    input  logic       clear,
`ifdef SW_LAP_EN
    input  logic       lap,
    output logic       lap_hold,
`endif
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       ovf
);

    sw_state_t state;

    logic  count_en, at_max, hold_ovf, hold_d;
    logic  cs_at, sec_at, min_at;
    logic  cs_carry, sec_carry, min_carry;
    bcd2_t cs_next, sec_next, min_next;

    assign count_en = tick_10ms && (state == RUN) && !clear;
    assign at_max   = cs_at && sec_at && min_at;
    // In stop mode the final tick is swallowed so every digit keeps its value.
    assign hold_ovf = OVF_STOP && count_en && at_max;

    bcd2_cnt #(.LIMIT(CS_MAX)) u_cs (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .en     (count_en && !hold_ovf),
        .q_next (cs_next),
        .at_lim (cs_at),
        .carry  (cs_carry)
    );

    bcd2_cnt #(.LIMIT(SEC_MAX)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .en     (cs_carry),
        .q_next (sec_next),
        .at_lim (sec_at),
        .carry  (sec_carry)
    );

    bcd2_cnt #(.LIMIT(int'(MAX_MIN))) u_min (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear),
        .en     (sec_carry),
        .q_next (min_next),
        .at_lim (min_at),
        .carry  (min_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            running <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf <= min_carry || hold_ovf;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (state == RUN && (start_stop || hold_ovf)) begin
                state   <= PAUSE;
                running <= 1'b0;
            end else if (state != RUN && start_stop) begin
                state   <= RUN;
                running <= 1'b1;
            end
        end
    end

`ifdef SW_LAP_EN
    logic hold_q;

    always_comb begin
        hold_d = hold_q;
        if (clear)                     hold_d = 1'b0;
        else if (lap && state == RUN)  hold_d = !hold_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= 1'b0;
        else      hold_q <= hold_d;
    end

    assign lap_hold = hold_q;
`else
    assign hold_d = 1'b0;
`endif

    // Display registers track the live count's next value, so they match it with no lag unless held.
    // NOTE: only these small control/data registers are reset; no memory arrays exist here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_bcd  <= 8'h00;
            sec_bcd <= 8'h00;
            min_bcd <= 8'h00;
        end else if (!hold_d) begin
            cs_bcd  <= cs_next;
            sec_bcd <= sec_next;
            min_bcd <= min_next;
        end
    end

endmodule

// File: tb/tb_sw_time_cnt.sv
// Directed bench for sw_time_cnt: two instances with MAX_MIN=1, wrap and stop overflow modes.
// Lap checks are compiled in when SW_LAP_EN is defined.
module tb_sw_time_cnt;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0, ss = 1'b0, clr = 1'b0;

    logic [7:0] cs_w, sec_w, min_w, cs_s, sec_s, min_s;
    logic       run_w, run_s, ovf_w, ovf_s;

    int tests = 0;
    int fails = 0;
    bit bad_digit = 1'b0;

`ifdef SW_LAP_EN
    logic lap = 1'b0;
    logic hold_w, hold_s;
`endif

    always #10 clk = ~clk;

    sw_time_cnt #(.MAX_MIN(7'd1), .OVF_STOP(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .tick_10ms  (tick),
        .start_stop (ss),
        .clear      (clr),
`ifdef SW_LAP_EN
        .lap        (lap),
        .lap_hold   (hold_w),
`endif
        .cs_bcd     (cs_w),
        .sec_bcd    (sec_w),
        .min_bcd    (min_w),
        .running    (run_w),
        .ovf        (ovf_w)
    );

    sw_time_cnt #(.MAX_MIN(7'd1), .OVF_STOP(1'b1)) dut_stop (
        .clk        (clk),
        .rst        (rst),
        .tick_10ms  (tick),
        .start_stop (ss),
        .clear      (clr),
`ifdef SW_LAP_EN
        .lap        (lap),
        .lap_hold   (hold_s),
`endif
        .cs_bcd     (cs_s),
        .sec_bcd    (sec_s),
        .min_bcd    (min_s),
        .running    (run_s),
        .ovf        (ovf_s)
    );

    function automatic bit has_bad(input logic [23:0] v);
        bit b = 1'b0;
        for (int i = 0; i < 6; i++) if (v[i*4 +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // Any nibble above 9 on any cycle is latched here and checked later.
    always @(negedge clk) begin
        if (rst && (has_bad({min_w, sec_w, cs_w}) || has_bad({min_s, sec_s, cs_s})))
            bad_digit = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic t, input logic s, input logic c, input logic l);
        tick = t; ss = s; clr = c;
`ifdef SW_LAP_EN
        lap = l;
`else
        if (l) $display("lap ignored in this build");
`endif
        @(posedge clk);
        #1;
        tick = 1'b0; ss = 1'b0; clr = 1'b0;
`ifdef SW_LAP_EN
        lap = 1'b0;
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_both(input string tag, input logic [23:0] exp, input logic run_exp);
        check({tag, " wrap val"}, {min_w, sec_w, cs_w}, exp);
        check({tag, " stop val"}, {min_s, sec_s, cs_s}, exp);
        check({tag, " wrap run"}, 24'(run_w), 24'(run_exp));
        check({tag, " stop run"}, 24'(run_s), 24'(run_exp));
    endtask

    initial begin
        // Reset state
        #35;
        check_both("reset", 24'h000000, 1'b0);
        check("reset ovf", {22'd0, ovf_w, ovf_s}, 24'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Start then 100 ticks -> 00:01.00
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        check_both("start", 24'h000000, 1'b1);
        ticks(100);
        check_both("100 ticks", 24'h000100, 1'b1);

        // Up to 00:59.99 then one tick carries into minutes
        ticks(5899);
        check_both("at 00:59.99", 24'h005999, 1'b1);
        ticks(1);
        check_both("min carry", 24'h010000, 1'b1);
        check("no A-F digits", 24'(bad_digit), 24'h0);

        // Up to MAX_MIN:59.99 (01:59.99), then overflow
        ticks(5999);
        check_both("at max", 24'h015999, 1'b1);
        ticks(1);
        check("ovf wrap val", {min_w, sec_w, cs_w}, 24'h000000);
        check("ovf wrap run", 24'(run_w), 24'h1);
        check("ovf wrap pulse", 24'(ovf_w), 24'h1);
        check("ovf stop val", {min_s, sec_s, cs_s}, 24'h015999);
        check("ovf stop run", 24'(run_s), 24'h0);
        check("ovf stop pulse", 24'(ovf_s), 24'h1);
        ticks(1);
        check("ovf one cycle", {22'd0, ovf_w, ovf_s}, 24'h0);
        check("stop held", {min_s, sec_s, cs_s}, 24'h015999);
        check("wrap continues", {min_w, sec_w, cs_w}, 24'h000001);

        // Clear returns both to IDLE at zero
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check_both("clear", 24'h000000, 1'b0);

        // Tick + start_stop in RUN: counts and pauses; further tick ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        check_both("at 00:00.05", 24'h000005, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_both("tick+ss run", 24'h000006, 1'b0);
        ticks(1);
        check_both("tick in pause", 24'h000006, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check_both("tick+ss pause", 24'h000006, 1'b1);

        // Clear beats start_stop and tick at 00:12.34
        ticks(1228);
        check_both("at 00:12.34", 24'h001234, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check_both("clear priority", 24'h000000, 1'b0);
        ticks(3);
        check_both("tick in idle", 24'h000000, 1'b0);

        // Asynchronous reset mid-count; restart needs start_stop
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_both("pre reset", 24'h000010, 1'b1);
        #3 rst = 1'b0;
        #1;
        check_both("async reset", 24'h000000, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        ticks(5);
        check_both("idle after reset", 24'h000000, 1'b0);

`ifdef SW_LAP_EN
        // Lap capture at 00:03.00, hold across 200 ticks, release shows 00:05.00
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(300);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_both("lap capture", 24'h000300, 1'b1);
        check("lap hold set", {22'd0, hold_w, hold_s}, 24'h3);
        ticks(200);
        check_both("lap held", 24'h000300, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check_both("lap release", 24'h000500, 1'b1);
        check("lap hold clr", {22'd0, hold_w, hold_s}, 24'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap in pause", {22'd0, hold_w, hold_s}, 24'h0);
`endif

        check("no A-F digits end", 24'(bad_digit), 24'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
